// File: rtl/tnoc_config_pkg.sv
// Shared NoC router definitions: output-port encoding, flit field layout and
// the virtual-channel state type.
package tnoc_config_pkg;

    localparam int unsigned PORTS = 5;

    // Head/tail flags are counted down from the flit MSB; dest_y sits directly above dest_x.
    localparam int unsigned FLIT_HEAD_FROM_MSB = 0;
    localparam int unsigned FLIT_TAIL_FROM_MSB = 1;
    localparam int unsigned DEST_X_LSB         = 0;

    typedef enum logic [2:0] {
        XP = 3'd0,
        XM = 3'd1,
        YP = 3'd2,
        YM = 3'd3,
        L  = 3'd4
    } tnoc_port_e;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACTIVE,
        DISCARD
    } tnoc_vc_state_e;

    function automatic tnoc_port_e xy_route(input int unsigned dx, input int unsigned dy,
                                            input int unsigned x, input int unsigned y);
        if (dx > x) return XP;
        if (dx < x) return XM;
        if (dy > y) return YP;
        if (dy < y) return YM;
        return L;
    endfunction

    function automatic logic [PORTS-1:0] port_onehot(input tnoc_port_e p);
        return {{(PORTS-1){1'b0}}, 1'b1} << p;
    endfunction

endpackage

// File: rtl/tnoc_vc_fifo.sv
// Single virtual-channel flit FIFO; a push while full is dropped, with fullness
// judged before any same-cycle pop.
module tnoc_vc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/tnoc_vc_input_unit.sv
// Router input port: per-VC FIFOs with XY route compute, packet-level port lock,
// round-robin flit arbitration across VCs and credit return upstream.
module tnoc_vc_input_unit
    import tnoc_config_pkg::*;
#(
    parameter int unsigned      CHANNELS        = 2,
    parameter int unsigned      DEPTH           = 4,
    parameter int unsigned      FLIT_WIDTH      = 64,
    parameter int unsigned      X_WIDTH         = 3,
    parameter int unsigned      Y_WIDTH         = 3,
    parameter int unsigned      X               = 0,
    parameter int unsigned      Y               = 0,
    parameter logic [PORTS-1:0] AVAILABLE_PORTS = 5'b11111,
    localparam int unsigned     VC_W            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    input  logic [VC_W-1:0]           i_vc,
    input  logic [FLIT_WIDTH-1:0]     i_flit,
    output logic [CHANNELS-1:0]       o_credit,
    output logic [CHANNELS-1:0]       o_req_valid,
    output logic [CHANNELS*PORTS-1:0] o_req_port,
    input  logic [CHANNELS-1:0]       i_req_grant,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [VC_W-1:0]           o_vc,
    output logic [PORTS-1:0]          o_port,
    output logic [FLIT_WIDTH-1:0]     o_flit,
    output logic [CHANNELS-1:0]       o_release,
    output logic                      o_overflow,
    output logic                      o_route_error
);
    localparam int unsigned HEAD_BIT   = FLIT_WIDTH - 1 - FLIT_HEAD_FROM_MSB;
    localparam int unsigned TAIL_BIT   = FLIT_WIDTH - 1 - FLIT_TAIL_FROM_MSB;
    localparam int unsigned DEST_Y_LSB = DEST_X_LSB + X_WIDTH;

    logic [FLIT_WIDTH-1:0] w_head_flit [CHANNELS];
    logic [PORTS-1:0]      w_route     [CHANNELS];
    logic [PORTS-1:0]      r_port      [CHANNELS];
    logic [PORTS-1:0]      w_port_next [CHANNELS];
    tnoc_vc_state_e        r_state     [CHANNELS];
    tnoc_vc_state_e        w_state_next[CHANNELS];

    logic [CHANNELS-1:0] w_push;
    logic [CHANNELS-1:0] w_pop;
    logic [CHANNELS-1:0] w_empty;
    logic [CHANNELS-1:0] w_full;
    logic [CHANNELS-1:0] w_is_head;
    logic [CHANNELS-1:0] w_is_tail;
    logic [CHANNELS-1:0] w_eligible;

    logic [VC_W-1:0]       r_rr_ptr;
    logic [VC_W-1:0]       r_hold_vc;
    logic                  r_hold;
    logic [VC_W-1:0]       w_hi_sel;
    logic [VC_W-1:0]       w_lo_sel;
    logic                  w_hi_found;
    logic                  w_lo_found;
    logic [VC_W-1:0]       w_sel;
    logic                  w_sel_valid;
    logic                  w_xfer;
    logic [FLIT_WIDTH-1:0] w_sel_flit;
    logic [PORTS-1:0]      w_sel_port;

    logic r_overflow;
    logic r_route_error;
    logic w_route_err_set;

    for (genvar v = 0; v < CHANNELS; v++) begin : g_vc
        assign w_push[v] = i_valid && (i_vc == VC_W'(v));

        tnoc_vc_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (FLIT_WIDTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[v]),
            .i_data  (i_flit),
            .i_pop   (w_pop[v]),
            .o_data  (w_head_flit[v]),
            .o_empty (w_empty[v]),
            .o_full  (w_full[v])
        );

        assign w_is_head[v]  = w_head_flit[v][HEAD_BIT];
        assign w_is_tail[v]  = w_head_flit[v][TAIL_BIT];
        assign w_route[v]    = port_onehot(xy_route(32'(w_head_flit[v][DEST_X_LSB +: X_WIDTH]),
                                                    32'(w_head_flit[v][DEST_Y_LSB +: Y_WIDTH]),
                                                    X, Y));
        assign w_eligible[v] = (r_state[v] == ACTIVE) && !w_empty[v];
    end

    // Round-robin: lowest eligible VC at or above the pointer, else lowest overall.
    always_comb begin
        w_hi_sel   = '0;
        w_lo_sel   = '0;
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        for (int v = CHANNELS - 1; v >= 0; v--) begin
            if (w_eligible[v]) begin
                w_lo_sel   = VC_W'(v);
                w_lo_found = 1'b1;
                if (VC_W'(v) >= r_rr_ptr) begin
                    w_hi_sel   = VC_W'(v);
                    w_hi_found = 1'b1;
                end
            end
        end
    end

    // A stalled offer stays locked to its VC until the crossbar takes it.
    assign w_sel       = r_hold ? r_hold_vc : (w_hi_found ? w_hi_sel : w_lo_sel);
    assign w_sel_valid = r_hold || w_lo_found;
    assign w_xfer      = w_sel_valid && i_ready;

    always_comb begin
        w_sel_flit = '0;
        w_sel_port = '0;
        o_req_port = '0;
        for (int v = 0; v < CHANNELS; v++) begin
            if (VC_W'(v) == w_sel) begin
                w_sel_flit = w_head_flit[v];
                w_sel_port = r_port[v];
            end
            o_req_valid[v] = (r_state[v] == REQ);
            if (r_state[v] == REQ) o_req_port[v*PORTS +: PORTS] = r_port[v];
            w_pop[v]     = (w_xfer && (VC_W'(v) == w_sel))
                        || ((r_state[v] == DISCARD) && !w_empty[v]);
            o_release[v] = w_xfer && (VC_W'(v) == w_sel) && w_is_tail[v];
        end
    end

    always_comb begin
        w_route_err_set = 1'b0;
        for (int v = 0; v < CHANNELS; v++) begin
            w_state_next[v] = r_state[v];
            w_port_next[v]  = r_port[v];
            case (r_state[v])
                IDLE: begin
                    if (!w_empty[v]) begin
                        if (!w_is_head[v]) begin
                            w_state_next[v] = DISCARD;
                        end else begin
                            w_port_next[v] = w_route[v];
                            if ((w_route[v] & AVAILABLE_PORTS) != '0) begin
                                w_state_next[v] = REQ;
                            end else begin
                                w_state_next[v] = DISCARD;
                                w_route_err_set = 1'b1;
                            end
                        end
                    end
                end
                REQ:     if (i_req_grant[v]) w_state_next[v] = ACTIVE;
                ACTIVE:  if (w_pop[v] && w_is_tail[v]) w_state_next[v] = IDLE;
                DISCARD: if (w_pop[v] && w_is_tail[v]) w_state_next[v] = IDLE;
                default: w_state_next[v] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < CHANNELS; v++) begin
                r_state[v] <= IDLE;
                r_port[v]  <= '0;
            end
            r_rr_ptr      <= '0;
            r_hold        <= 1'b0;
            r_hold_vc     <= '0;
            r_overflow    <= 1'b0;
            r_route_error <= 1'b0;
        end else begin
            for (int v = 0; v < CHANNELS; v++) begin
                r_state[v] <= w_state_next[v];
                r_port[v]  <= w_port_next[v];
            end
            if (w_xfer) begin
                r_rr_ptr <= (w_sel == VC_W'(CHANNELS - 1)) ? '0 : w_sel + 1'b1;
            end
            r_hold        <= w_sel_valid && !i_ready;
            r_hold_vc     <= w_sel;
            r_overflow    <= r_overflow || ((w_push & w_full) != '0);
            r_route_error <= r_route_error || w_route_err_set;
        end
    end

    assign o_credit      = w_pop;
    assign o_valid       = w_sel_valid;
    assign o_vc          = w_sel_valid ? w_sel : '0;
    assign o_port        = w_sel_valid ? w_sel_port : '0;
    assign o_flit        = w_sel_valid ? w_sel_flit : '0;
    assign o_overflow    = r_overflow;
    assign o_route_error = r_route_error;

endmodule
